// File: rtl/conv_layer_pkg.sv
// conv_layer_pkg: shared widths and helpers for the conv_layer datapath.
//   bit_acc    : exact accumulator width for a KSIZE-tap signed dot product
//   sat_max/min: saturation limits of a signed BIT_DATA-bit result
//   slice_lsb  : LSB of element idx inside a packed vector of w-bit elements
//   addr_width : index width for n entries, never less than 1
package conv_layer_pkg;

  // Each product is 2*bit_data bits. Summing ksize of them can grow the
  // magnitude by at most clog2(ksize) bits, so this width never overflows.
  function automatic int bit_acc(input int bit_data, input int ksize);
    return 2 * bit_data + $clog2(ksize);
  endfunction

  function automatic int sat_max(input int bit_data);
    return (1 << (bit_data - 1)) - 1;
  endfunction

  function automatic int sat_min(input int bit_data);
    return -(1 << (bit_data - 1));
  endfunction

  function automatic int slice_lsb(input int idx, input int w);
    return idx * w;
  endfunction

  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_channel.sv
// conv_channel: one output channel of conv_layer, as a three-stage pipe.
//   stage 1: KSIZE signed products of window x and weights w
//   stage 2: exact signed sum of the products
//   stage 3: arithmetic right shift by scale, saturate, ReLU, register to z
// scale is carried down the pipe with the window it was sampled with.
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-low reset
//   en           : global advance; every stage loads only when en=1
//   x, w         : packed signed window and weights, tap k at [BIT_DATA*k +: BIT_DATA]
//   scale        : unsigned right-shift amount for this window
//   z            : ReLU result, always >= 0
//   zero         : z == 0 (only when CONV_LAYER_ZERO_MASK_EN is defined)
module conv_channel
  import conv_layer_pkg::*;
#(
  parameter int BIT_DATA = 8,
  parameter int KSIZE    = 9,
  parameter int BIT_SH   = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      en,
  input  logic [KSIZE*BIT_DATA-1:0] x,
  input  logic [KSIZE*BIT_DATA-1:0] w,
  input  logic [BIT_SH-1:0]         scale,
  output logic [BIT_DATA-1:0]       z
`ifdef CONV_LAYER_ZERO_MASK_EN
  ,
  output logic                      zero
`endif
);

  localparam int BIT_PROD = 2 * BIT_DATA;
  localparam int BIT_ACC  = bit_acc(BIT_DATA, KSIZE);
  localparam logic signed [BIT_ACC-1:0] SAT_HI = BIT_ACC'(sat_max(BIT_DATA));
  localparam logic signed [BIT_ACC-1:0] SAT_LO = BIT_ACC'(sat_min(BIT_DATA));

  // Operands are sign-extended to the product width before multiplying, so
  // the truncated product is the exact signed result.
  function automatic logic signed [BIT_PROD-1:0] mul(
    input logic signed [BIT_DATA-1:0] a,
    input logic signed [BIT_DATA-1:0] b
  );
    return BIT_PROD'(a) * BIT_PROD'(b);
  endfunction

  logic signed [BIT_PROD-1:0] prod_q [KSIZE];
  logic [BIT_SH-1:0]          scale1_q;
  logic [BIT_SH-1:0]          scale2_q;
  logic signed [BIT_ACC-1:0]  acc_d;
  logic signed [BIT_ACC-1:0]  acc_q;
  logic signed [BIT_ACC-1:0]  shifted;
  logic signed [BIT_ACC-1:0]  sat;
  logic [BIT_DATA-1:0]        z_d;

  // Stage 1: products.
  // NOTE: state is assigned with <= so every register samples pre-edge values;
  // with = a later stage would see this cycle's new value and skip a stage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < KSIZE; k++) prod_q[k] <= '0;
      scale1_q <= '0;
    end else if (en) begin
      for (int k = 0; k < KSIZE; k++) begin
        prod_q[k] <= mul(x[slice_lsb(k, BIT_DATA) +: BIT_DATA],
                         w[slice_lsb(k, BIT_DATA) +: BIT_DATA]);
      end
      scale1_q <= scale;
    end
  end

  // Stage 2: exact sum.
  // NOTE: acc_d is given a value before the loop so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    acc_d = '0;
    for (int k = 0; k < KSIZE; k++) acc_d = acc_d + BIT_ACC'(prod_q[k]);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q    <= '0;
      scale2_q <= '0;
    end else if (en) begin
      acc_q    <= acc_d;
      scale2_q <= scale1_q;
    end
  end

  // Stage 3: floor shift, saturate, ReLU. The low clamp is kept so the
  // saturated value stays meaningful if ReLU is ever made optional.
  always_comb begin
    shifted = acc_q >>> scale2_q;
    if (shifted > SAT_HI)      sat = SAT_HI;
    else if (shifted < SAT_LO) sat = SAT_LO;
    else                       sat = shifted;
    z_d = sat[BIT_ACC-1] ? '0 : sat[BIT_DATA-1:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      z <= '0;
    end else if (en) begin
      z <= z_d;
    end
  end

`ifdef CONV_LAYER_ZERO_MASK_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      zero <= 1'b0;
    end else if (en) begin
      zero <= (z_d == '0);
    end
  end
`endif

endmodule

// File: rtl/conv_layer.sv
// conv_layer: FILTERS parallel convolution channels over a KSIZE-tap window,
// with a per-filter weight store and a valid/ready stream with backpressure.
// A window accepted in cycle n appears on z in cycle n+3. The whole pipe
// advances together when the output slot is empty or being taken.
// Optional feature: define CONV_LAYER_ZERO_MASK_EN to add z_zero, a per-channel
// flag registered alongside z that is 1 when that channel's result is 0.
// Ports:
//   clock, reset      : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready : window handshake; x and scale sampled on acceptance
//   x                 : packed signed window, tap k at [BIT_DATA*k +: BIT_DATA]
//   scale             : unsigned right-shift amount for this window
//   w_we/w_addr/w_data: write packed weights to filter w_addr
//   out_valid/out_ready: result handshake
//   z                 : channel i at [BIT_DATA*i +: BIT_DATA], always >= 0
//   z_zero            : (CONV_LAYER_ZERO_MASK_EN) bit i = channel i is zero
module conv_layer
  import conv_layer_pkg::*;
#(
  parameter int BIT_DATA = 8,
  parameter int KSIZE    = 9,
  parameter int FILTERS  = 4,
  parameter int BIT_SH   = 4
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [KSIZE*BIT_DATA-1:0]             x,
  input  logic [BIT_SH-1:0]                     scale,
  input  logic                                  w_we,
  input  logic [addr_width(FILTERS)-1:0]        w_addr,
  input  logic [KSIZE*BIT_DATA-1:0]             w_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [FILTERS*BIT_DATA-1:0]           z
`ifdef CONV_LAYER_ZERO_MASK_EN
  ,
  output logic [FILTERS-1:0]                    z_zero
`endif
);

  localparam int AW = addr_width(FILTERS);

  logic                      advance;
  logic                      v1_q;
  logic                      v2_q;
  logic                      v3_q;
  logic [KSIZE*BIT_DATA-1:0] w_q [FILTERS];
  logic [BIT_DATA-1:0]       z_ch [FILTERS];

  // Bubbles are not squeezed: the pipe only moves when the output slot frees.
  assign advance   = !v3_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = v3_q;

  // Weight store. Channels read the registered weights, so a write in the
  // same cycle as an acceptance only affects later windows. Indices with no
  // matching filter never match and are ignored.
  // NOTE: the weight array is reset explicitly because results must be
  // defined (zero) before any weight write; this costs a reset per bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int f = 0; f < FILTERS; f++) w_q[f] <= '0;
    end else if (w_we) begin
      for (int f = 0; f < FILTERS; f++) begin
        if (w_addr == AW'(f)) w_q[f] <= w_data;
      end
    end
  end

  // Valid pipe, one flag per stage, moving in lockstep with the datapath.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else if (advance) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
    end
  end

  for (genvar g = 0; g < FILTERS; g++) begin : g_ch
    conv_channel #(
      .BIT_DATA(BIT_DATA),
      .KSIZE   (KSIZE),
      .BIT_SH  (BIT_SH)
    ) u_ch (
      .clock(clock),
      .reset(reset),
      .en   (advance),
      .x    (x),
      .w    (w_q[g]),
      .scale(scale),
      .z    (z_ch[g])
`ifdef CONV_LAYER_ZERO_MASK_EN
      ,
      .zero (z_zero[g])
`endif
    );
  end

  always_comb begin
    z = '0;
    for (int i = 0; i < FILTERS; i++) z[slice_lsb(i, BIT_DATA) +: BIT_DATA] = z_ch[i];
  end

endmodule

// File: tb/tb_conv_layer.sv
// tb_conv_layer: directed vectors with hand-computed results. Stimulus pushes
// the expected z into a scoreboard on acceptance; a monitor pops and compares
// whenever a result is transferred. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
module tb_conv_layer;

  localparam int BIT_DATA = 8;
  localparam int KSIZE    = 9;
  localparam int FILTERS  = 4;
  localparam int BIT_SH   = 4;
  localparam int XW       = KSIZE * BIT_DATA;
  localparam int ZW       = FILTERS * BIT_DATA;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [XW-1:0]     x;
  logic [BIT_SH-1:0] scale;
  logic              w_we;
  logic [1:0]        w_addr;
  logic [XW-1:0]     w_data;
  logic              out_valid;
  logic              out_ready;
  logic [ZW-1:0]     z;
`ifdef CONV_LAYER_ZERO_MASK_EN
  logic [FILTERS-1:0] z_zero;
`endif

  conv_layer #(
    .BIT_DATA(BIT_DATA),
    .KSIZE   (KSIZE),
    .FILTERS (FILTERS),
    .BIT_SH  (BIT_SH)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .scale    (scale),
    .w_we     (w_we),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .z        (z)
`ifdef CONV_LAYER_ZERO_MASK_EN
    ,
    .z_zero   (z_zero)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [ZW-1:0] z;
    int            cyc;
    bit            lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [XW-1:0] rep(input logic [7:0] v);
    return {KSIZE{v}};
  endfunction

  // Tap k holds the value k.
  function automatic logic [XW-1:0] ramp();
    logic [XW-1:0] r;
    for (int k = 0; k < KSIZE; k++) r[8*k +: 8] = 8'(k);
    return r;
  endfunction

  function automatic logic [ZW-1:0] zv(input logic [7:0] c0, input logic [7:0] c1,
                                       input logic [7:0] c2, input logic [7:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  function automatic logic [FILTERS-1:0] zmask(input logic [ZW-1:0] e);
    logic [FILTERS-1:0] m;
    for (int i = 0; i < FILTERS; i++) m[i] = (e[8*i +: 8] == 8'd0);
    return m;
  endfunction

  // Monitor: a result transfers at the next edge when out_valid && out_ready.
  always @(negedge clock) begin
    exp_t e;
    if (reset && out_valid && out_ready) begin
      check("sb_has_entry", 64'(sb.size() > 0), 64'(1));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("z", 64'(z), 64'(e.z));
`ifdef CONV_LAYER_ZERO_MASK_EN
        check("z_zero", 64'(z_zero), 64'(zmask(e.z)));
`endif
        if (e.lat) check("latency", 64'(cyc - e.cyc), 64'(3));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic write_w(input int f, input logic [XW-1:0] d);
    w_we   = 1'b1;
    w_addr = 2'(f);
    w_data = d;
    step();
    w_we   = 1'b0;
  endtask

  // Presents one window and waits (bounded) until it is accepted.
  task automatic send(input logic [XW-1:0] xv, input logic [BIT_SH-1:0] sc,
                      input logic [ZW-1:0] ez, input bit lat);
    bit done = 1'b0;
    in_valid = 1'b1;
    x        = xv;
    scale    = sc;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clock);
      if (in_ready) begin
        sb.push_back('{z: ez, cyc: cyc, lat: lat});
        done = 1'b1;
      end
      step();
    end
    check("accept_in_time", 64'(done), 64'(1));
  endtask

  task automatic drain();
    for (int t = 0; t < 40 && sb.size() != 0; t++) @(negedge clock);
    check("drain_empty", 64'(sb.size()), 64'(0));
    step();
  endtask

  // Backpressure window i carries value i+1 on every tap at scale 5;
  // channel 0 (weights 127) gives floor(1143*(i+1)/32) clamped to 127.
  logic [7:0] bp_ch0 [6] = '{8'd35, 8'd71, 8'd107, 8'd127, 8'd127, 8'd127};

  initial begin
    int accepted;
    reset     = 1'b0;
    in_valid  = 1'b1;
    x         = rep(8'h11);
    scale     = '0;
    w_we      = 1'b0;
    w_addr    = '0;
    w_data    = '0;
    out_ready = 1'b1;

    // Reset held with a window offered: nothing may come out.
    repeat (3) begin
      @(negedge clock);
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_z", 64'(z), 64'(0));
`ifdef CONV_LAYER_ZERO_MASK_EN
      check("rst_z_zero", 64'(z_zero), 64'(0));
`endif
    end
    reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    check("in_ready_after_rst", 64'(in_ready), 64'(1));
    step();

    // Filter 0 all ones, x all 2: 9*2 = 18.
    write_w(0, rep(8'd1));
    send(rep(8'd2), 4'd0, zv(8'd18, 0, 0, 0), 1'b1);
    in_valid = 1'b0;
    drain();

    // Filter 0 all 127, x all 127: sum 145161, back-to-back with new scales.
    write_w(0, rep(8'd127));
    send(rep(8'd127), 4'd0,  zv(8'd127, 0, 0, 0), 1'b1);
    send(rep(8'd127), 4'd11, zv(8'd70,  0, 0, 0), 1'b1);
    send(rep(8'd127), 4'd15, zv(8'd4,   0, 0, 0), 1'b1);
    in_valid = 1'b0;
    drain();

    // Filter 1 all -1.
    write_w(1, rep(8'hFF));
    send(rep(8'd5),  4'd0, zv(8'd127, 8'd0, 0, 0), 1'b1); // ch1 -45 -> ReLU 0
    send(rep(8'hFF), 4'd0, zv(8'd0,   8'd9, 0, 0), 1'b1); // ch0 -1143 -> 0, ch1 9
    send(rep(8'hFF), 4'd2, zv(8'd0,   8'd2, 0, 0), 1'b1); // 9>>2 floors to 2
    send(ramp(),     4'd6, zv(8'd71,  8'd0, 0, 0), 1'b1); // 4572>>6 = 71, -36>>6 = -1
    in_valid = 1'b0;
    drain();

    // Backpressure: only three windows fit while out_ready is low.
    out_ready = 1'b0;
    accepted  = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      x        = rep(8'(i + 1));
      scale    = 4'd5;
      @(negedge clock);
      if (in_ready) begin
        sb.push_back('{z: zv(bp_ch0[i], 0, 0, 0), cyc: cyc, lat: 1'b0});
        accepted++;
      end
      if (i >= 3) begin
        check("bp_out_valid_held", 64'(out_valid), 64'(1));
        check("bp_z_held", 64'(z), 64'(zv(8'd35, 0, 0, 0)));
      end
      step();
    end
    in_valid = 1'b0;
    @(negedge clock);
    check("bp_accepted", 64'(accepted), 64'(3));
    check("bp_in_ready_low", 64'(in_ready), 64'(0));
    step();
    out_ready = 1'b1;
    drain();

    // Weight write to filter 2 in the same cycle as an accepted window.
    w_we   = 1'b1;
    w_addr = 2'd2;
    w_data = rep(8'd3);
    send(rep(8'd1), 4'd0, zv(8'd127, 0, 8'd0,  0), 1'b1);
    w_we = 1'b0;
    send(rep(8'd1), 4'd0, zv(8'd127, 0, 8'd27, 0), 1'b1);
    in_valid = 1'b0;
    drain();

    // Reset mid-stream: in-flight windows and weights are discarded.
    repeat (4) send(rep(8'd2), 4'd0, zv(8'd127, 0, 8'd54, 0), 1'b1);
    in_valid = 1'b0;
    check("pre_rst_out_valid", 64'(out_valid), 64'(1));
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_z", 64'(z), 64'(0));
    sb.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    check("in_ready_after_mid_rst", 64'(in_ready), 64'(1));
    step();
    send(rep(8'd2), 4'd0, zv(0, 0, 0, 0), 1'b1);
    in_valid = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/conv_layer.md
# conv_layer

Parametrised successor to the fixed first convolution layer: FILTERS parallel channels, each computing a KSIZE-tap dot product of a packed input window against its own weight vector, then arithmetic right-shift scaling with saturation and ReLU. Adds per-filter weight addressing and a valid/ready streaming handshake with full backpressure. Sits between the window generator and the next layer's input buffer.

## Interface
- BIT_DATA, 8, signed width of each activation, weight and output element
- KSIZE, 9, taps per window (3x3)
- FILTERS, 4, parallel output channels
- BIT_SH, 4, width of the scale shift amount
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  input window valid
- in_ready  out  1  layer can accept a window this cycle
- x  in  KSIZE*BIT_DATA  packed signed window, tap k at [BIT_DATA*(k+1)-1 : BIT_DATA*k]
- scale  in  BIT_SH  unsigned right-shift amount, sampled with x
- w_we  in  1  weight write enable
- w_addr  in  clog2(FILTERS) (min 1)  target filter index
- w_data  in  KSIZE*BIT_DATA  packed signed weights, same tap layout as x
- out_valid  out  1  z holds a result
- out_ready  in  1  downstream accepts z
- z  out  FILTERS*BIT_DATA  channel i at [BIT_DATA*(i+1)-1 : BIT_DATA*i], always >= 0

## Operation
- Weight store: FILTERS registers of KSIZE*BIT_DATA; w_we=1 writes w_data to filter w_addr; w_addr >= FILTERS ignored. All weights 0 after reset.
- Accepted window (in_valid && in_ready) captures x and scale; every channel uses weights as they stand in that cycle's register state (a write in the same cycle does not affect that window; takes effect for the next accepted window).
- Stage 1: KSIZE signed products per channel, each 2*BIT_DATA bits.
- Stage 2: exact signed sum, BIT_ACC = 2*BIT_DATA + clog2(KSIZE) bits; no overflow possible.
- Stage 3: arithmetic right shift by scale (floor, no rounding); saturate to [-(2^(BIT_DATA-1)), 2^(BIT_DATA-1)-1]; ReLU forces negatives to 0; register to z.
- scale travels with its window through the pipe; changing scale between windows is legal every cycle.
- Result order equals acceptance order; no drop, no duplication.

## Timing
- Reset (reset=0): all pipeline valids 0, out_valid=0, z=0, weights 0, in_ready=1 on release.
- Latency: window accepted in cycle n appears on z with out_valid=1 in cycle n+3.
- Throughput: one window per cycle while out_ready=1.
- Global stall: advance = !out_valid || out_ready; all three stages move only on advance; in_ready = advance. Bubbles are not squeezed.
- out_valid && !out_ready: z and out_valid held stable until accepted.
- Pipe holds at most 3 windows; with out_ready=0 and a full pipe in_ready=0.
- Reset asserted mid-stream discards all in-flight windows and clears weights; first output after release requires fresh weights.

## Configuration
- CONV_LAYER_ZERO_MASK_EN defined: extra output z_zero [FILTERS-1:0], registered alongside z; bit i =1 when channel i result is 0 (ReLU clamp or shifted-to-zero). Reset value 0. Feeds downstream early-termination logic.
- Undefined: port and logic absent; all other behaviour identical.

## Structure
- Shared package: BIT_ACC width function, saturation max/min constants, packed-slice helper for tap/channel indexing.
- One sub-module conv_channel: products, sum, shift/saturate/ReLU for one filter with stage enable input; instantiated FILTERS times via generate. Handshake, weight store and valid pipe live in conv_layer.

## Test plan
(BIT_DATA=8, KSIZE=9, FILTERS=4, BIT_SH=4)
- Reset: hold reset=0 with in_valid=1 -> out_valid=0, z=0, no acceptance; after release in_ready=1.
- Weights filter0 all 1, others 0; x all 2, scale 0 -> 3 cycles later z ch0=18, ch1..3=0.
- Filter0 weights all 127, x all 127 (sum 145161): scale 0 -> 127 (saturated); scale 11 -> 70; scale 15 -> 4.
- Filter1 weights all -1, x all 5, scale 0 -> ch1=0; with CONV_LAYER_ZERO_MASK_EN z_zero[1]=1, z_zero[0]=1 if filter0 zero weights.
- Backpressure: out_ready=0 for 6 cycles, in_valid=1 with distinct windows -> exactly 3 accepted, in_ready=0 afterwards, z stable; out_ready=1 -> results drain in order, no loss.
- Weight write to filter2 in same cycle as an accepted window -> that window uses old weights, next window uses new; reset mid-stream -> out_valid drops to 0 immediately, z=0.
